// File: rtl/bank_row_cache.sv
// Bank controller: single-port BRAM of grid rows behind a small write-back row cache.
// Define BANK_FLUSH_EN to add flush_req and a FLUSH state that writes back dirty lines.
module bank_row_cache #(
  parameter int ROW_W  = 144,
  parameter int TX_W   = 32,
  parameter int PAD    = 1,
  parameter int DEPTH  = 64,
  parameter int LINES  = 2,
  parameter int ROW_AW = $clog2(DEPTH),
  parameter int COL_AW = $clog2(ROW_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ROW_AW-1:0] req_row,
  input  logic [COL_AW-1:0] req_col,
  input  logic [TX_W-1:0]   req_data,
`ifdef BANK_FLUSH_EN
  input  logic              flush_req,
`endif
  output logic              req_ready,
  output logic              resp_valid,
  output logic [TX_W-1:0]   resp_data,
  output logic              busy,
  output logic              flush_done
);

  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int XW = ROW_W + TX_W;
  localparam logic [COL_AW-1:0] COL_MASK = ~COL_AW'(TX_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FETCH,
    S_FILL,
    S_FLUSH
  } state_t;

  state_t state_q;

  logic [ROW_W-1:0]  data_q [LINES];
  logic [ROW_AW-1:0] tag_q  [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [DEPTH-1:0]  written_q;
  logic [LW-1:0]     rr_q;
  logic [LW-1:0]     vic_q;

  logic              lat_write_q;
  logic [ROW_AW-1:0] lat_row_q;
  logic [COL_AW-1:0] lat_col_q;
  logic [TX_W-1:0]   lat_data_q;

  logic              resp_valid_q;
  logic [TX_W-1:0]   resp_data_q;
  logic              flush_done_q;

  logic [ROW_W-1:0]  mem [DEPTH];
  logic [ROW_W-1:0]  bram_q;
  logic              mem_we;
  logic [ROW_AW-1:0] mem_addr;
  logic [ROW_W-1:0]  mem_wdata;

  logic              hit;
  logic [LW-1:0]     hit_idx;
  logic              any_inv;
  logic [LW-1:0]     inv_idx;
  logic [LW-1:0]     vic;
  logic [LW-1:0]     rr_next;
  logic [31:0]       req_base;
  logic [31:0]       lat_base;
  logic [ROW_W-1:0]  fill_row;

  function automatic logic [31:0] slice_base(
    input logic [COL_AW-1:0] col
  );
    return 32'(col & COL_MASK) + 32'(PAD);
  endfunction

  function automatic logic [TX_W-1:0] get_slice(
    input logic [ROW_W-1:0] row,
    input logic [31:0]      base
  );
    return TX_W'({{TX_W{1'b0}}, row} >> base);
  endfunction

  function automatic logic [ROW_W-1:0] put_slice(
    input logic [ROW_W-1:0] row,
    input logic [31:0]      base,
    input logic [TX_W-1:0]  data
  );
    logic [ROW_W-1:0] m;
    logic [ROW_W-1:0] d;
    m = ROW_W'(XW'({TX_W{1'b1}}) << base);
    d = ROW_W'(XW'(data) << base);
    return (row & ~m) | d;
  endfunction

  assign req_base = slice_base(req_col);
  assign lat_base = slice_base(lat_col_q);
  assign fill_row = written_q[lat_row_q] ? bram_q : '0;
  assign rr_next  = (rr_q == LW'(LINES - 1)) ? '0 : rr_q + 1'b1;

  // lowest-index match / lowest-index invalid line
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    any_inv = 1'b0;
    inv_idx = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == req_row) begin
        hit     = 1'b1;
        hit_idx = LW'(i);
      end
      if (!valid_q[i]) begin
        any_inv = 1'b1;
        inv_idx = LW'(i);
      end
    end
    vic = any_inv ? inv_idx : rr_q;
  end

`ifdef BANK_FLUSH_EN
  logic          fl_any;
  logic          fl_more;
  logic [LW-1:0] fl_idx;

  always_comb begin
    fl_any = 1'b0;
    fl_idx = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (dirty_q[i]) begin
        fl_any = 1'b1;
        fl_idx = LW'(i);
      end
    end
    fl_more = ($countones(dirty_q) > 1);
  end

  assign req_ready = (state_q == S_IDLE) && !flush_req;
`else
  assign req_ready = (state_q == S_IDLE);
`endif

  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign flush_done = flush_done_q;

  // a write landing on the reset edge is suppressed: reset abandons dirty data
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = lat_row_q;
    mem_wdata = data_q[vic_q];
    if (state_q == S_WB) begin
      mem_we   = !reset;
      mem_addr = tag_q[vic_q];
    end
`ifdef BANK_FLUSH_EN
    if (state_q == S_FLUSH && fl_any) begin
      mem_we    = !reset;
      mem_addr  = tag_q[fl_idx];
      mem_wdata = data_q[fl_idx];
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    bram_q <= mem[mem_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      written_q    <= '0;
      rr_q         <= '0;
      vic_q        <= '0;
      lat_write_q  <= 1'b0;
      lat_row_q    <= '0;
      lat_col_q    <= '0;
      lat_data_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      flush_done_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      flush_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
`ifdef BANK_FLUSH_EN
          if (flush_req) begin
            state_q <= S_FLUSH;
          end else
`endif
          if (req_valid) begin
            if (hit) begin
              resp_valid_q <= 1'b1;
              if (req_write) begin
                data_q[hit_idx] <= put_slice(data_q[hit_idx], req_base, req_data);
                dirty_q[hit_idx] <= 1'b1;
                written_q[req_row] <= 1'b1;
              end else begin
                resp_data_q <= get_slice(data_q[hit_idx], req_base);
              end
            end else begin
              lat_write_q <= req_write;
              lat_row_q   <= req_row;
              lat_col_q   <= req_col;
              lat_data_q  <= req_data;
              vic_q       <= vic;
              if (!any_inv) begin
                rr_q <= rr_next;
              end
              if (valid_q[vic] && dirty_q[vic]) begin
                state_q <= S_WB;
              end else begin
                state_q <= S_FETCH;
              end
            end
          end
        end
        S_WB: begin
          dirty_q[vic_q] <= 1'b0;
          state_q        <= S_FETCH;
        end
        S_FETCH: begin
          state_q <= S_FILL;
        end
        S_FILL: begin
          tag_q[vic_q]   <= lat_row_q;
          valid_q[vic_q] <= 1'b1;
          resp_valid_q   <= 1'b1;
          if (lat_write_q) begin
            data_q[vic_q] <= put_slice(fill_row, lat_base, lat_data_q);
            dirty_q[vic_q] <= 1'b1;
            written_q[lat_row_q] <= 1'b1;
          end else begin
            data_q[vic_q]  <= fill_row;
            dirty_q[vic_q] <= 1'b0;
            resp_data_q    <= get_slice(fill_row, lat_base);
          end
          state_q <= S_IDLE;
        end
`ifdef BANK_FLUSH_EN
        S_FLUSH: begin
          if (fl_any) begin
            dirty_q[fl_idx] <= 1'b0;
          end
          if (!fl_more) begin
            flush_done_q <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bank_row_cache.sv
// Bench for bank_row_cache: directed table, corner sequences, random vs. row-array model.
// Flush checks compile only when BANK_FLUSH_EN is defined.
module tb_bank_row_cache;

  localparam int ROW_W  = 144;
  localparam int TX_W   = 32;
  localparam int PAD    = 1;
  localparam int DEPTH  = 64;
  localparam int LINES  = 2;
  localparam int ROW_AW = 6;
  localparam int COL_AW = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_write;
  logic [ROW_AW-1:0] req_row;
  logic [COL_AW-1:0] req_col;
  logic [TX_W-1:0]   req_data;
  logic              req_ready;
  logic              resp_valid;
  logic [TX_W-1:0]   resp_data;
  logic              busy;
  logic              flush_done;
`ifdef BANK_FLUSH_EN
  logic              flush_req;
`endif

  always #5 clock = ~clock;

  bank_row_cache #(
    .ROW_W(ROW_W), .TX_W(TX_W), .PAD(PAD), .DEPTH(DEPTH),
    .LINES(LINES), .ROW_AW(ROW_AW), .COL_AW(COL_AW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_row    (req_row),
    .req_col    (req_col),
    .req_data   (req_data),
`ifdef BANK_FLUSH_EN
    .flush_req  (flush_req),
`endif
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy),
    .flush_done (flush_done)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit        wr;
    int        row;
    int        col;
    bit [31:0] data;
    int        lat;
    bit [31:0] exp;
  } vec_t;

  vec_t tbl[13];

  // reference: the bank is a plain row array; cache only affects timing
  bit [ROW_W-1:0] mref [DEPTH];
  int  ctag   [LINES];
  bit  cval   [LINES];
  bit  cdirty [LINES];
  int  crr;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) mref[i] = '0;
    for (int i = 0; i < LINES; i++) begin
      ctag[i] = 0; cval[i] = 0; cdirty[i] = 0;
    end
    crr = 0;
  endfunction

  function automatic int model_access(bit wr, int row);
    int v;
    int lat;
    for (int i = 0; i < LINES; i++)
      if (cval[i] && ctag[i] == row) begin
        if (wr) cdirty[i] = 1;
        return 1;
      end
    v = -1;
    for (int i = LINES - 1; i >= 0; i--)
      if (!cval[i]) v = i;
    if (v < 0) begin
      v = crr;
      crr = (crr + 1) % LINES;
    end
    lat = (cval[v] && cdirty[v]) ? 4 : 3;
    ctag[v] = row; cval[v] = 1; cdirty[v] = wr;
    return lat;
  endfunction

  function automatic bit [31:0] model_read(int row, int col);
    bit [31:0] r;
    int base;
    r = 0;
    base = (col / TX_W) * TX_W + PAD;
    for (int k = 0; k < TX_W; k++)
      if (base + k < ROW_W) r[k] = mref[row][base + k];
    return r;
  endfunction

  function automatic void model_write(int row, int col, bit [31:0] d);
    int base;
    base = (col / TX_W) * TX_W + PAD;
    for (int k = 0; k < TX_W; k++)
      if (base + k < ROW_W) mref[row][base + k] = d[k];
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1; req_valid = 0;
`ifdef BANK_FLUSH_EN
    flush_req = 0;
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
  endtask

  // call at a negedge; returns cycles from accept to resp_valid (0 = none)
  task automatic do_req(input bit wr, input int row, input int col,
                        input bit [31:0] d, output int lat,
                        output bit [31:0] rd, output bit hs_ok);
    req_valid = 1; req_write = wr;
    req_row = ROW_AW'(row); req_col = COL_AW'(col); req_data = d;
    hs_ok = (req_ready === 1'b1);
    @(posedge clock);
    #1 req_valid = 0;
    lat = 0; rd = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      if (resp_valid === 1'b1) begin
        lat = n; rd = resp_data;
        if (busy !== 1'b0 || req_ready !== 1'b1) hs_ok = 0;
        break;
      end
      if (busy !== 1'b1 || req_ready !== 1'b0) hs_ok = 0;
    end
  endtask

  task automatic run_checked(string tag, bit wr, int row, int col,
                             bit [31:0] d, int elat, bit [31:0] erd);
    int lat;
    bit [31:0] rd;
    bit ok;
    do_req(wr, row, col, d, lat, rd, ok);
    check({tag, ".lat"}, lat, elat);
    check({tag, ".data"}, rd, erd);
    check({tag, ".hs"}, ok, 1);
  endtask

  int        lat;
  bit [31:0] rd;
  bit        ok;
  int        rows4[4];
  int        cols4[4];
  bit [31:0] exp4[4];

  initial begin
    reset = 1; req_valid = 0; req_write = 0;
    req_row = '0; req_col = '0; req_data = '0;
`ifdef BANK_FLUSH_EN
    flush_req = 0;
`endif

    tbl[0]  = '{0, 5,  40, 32'h0,        3, 32'h0};
    tbl[1]  = '{1, 3,  33, 32'hDEADBEEF, 3, 32'h0};
    tbl[2]  = '{0, 3,  40, 32'h0,        1, 32'hDEADBEEF};
    tbl[3]  = '{0, 3,  0,  32'h0,        1, 32'h0};
    tbl[4]  = '{0, 3,  100, 32'h0,       1, 32'h0};
    tbl[5]  = '{0, 3,  140, 32'h0,       1, 32'h0};
    tbl[6]  = '{1, 1,  0,  32'h11111111, 3, 32'h0};
    tbl[7]  = '{1, 2,  64, 32'h22222222, 4, 32'h0};
    tbl[8]  = '{1, 3,  128, 32'h33333333, 4, 32'h0};
    tbl[9]  = '{0, 1,  0,  32'h0,        4, 32'h11111111};
    tbl[10] = '{0, 3,  40, 32'h0,        1, 32'hDEADBEEF};
    tbl[11] = '{0, 3,  140, 32'h0,       1, 32'h00003333};
    tbl[12] = '{0, 1,  0,  32'h0,        1, 32'h11111111};

    do_reset();
    check("rst.ready", req_ready, 1);
    check("rst.resp_valid", resp_valid, 0);
    check("rst.resp_data", resp_data, 0);
    check("rst.busy", busy, 0);
    check("rst.flush_done", flush_done, 0);

    for (int i = 0; i < 13; i++)
      run_checked($sformatf("vec%0d", i), tbl[i].wr, tbl[i].row,
                  tbl[i].col, tbl[i].data, tbl[i].lat, tbl[i].exp);

    // back-to-back hits: L0 holds row 3, L1 holds row 1
    rows4 = '{1, 3, 1, 3};
    cols4 = '{0, 40, 0, 40};
    exp4  = '{32'h11111111, 32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF};
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; req_write = 0;
      req_row = ROW_AW'(rows4[i]); req_col = COL_AW'(cols4[i]);
      check($sformatf("b2b%0d.ready", i), req_ready, 1);
      @(posedge clock);
      @(negedge clock);
      check($sformatf("b2b%0d.valid", i), resp_valid, 1);
      check($sformatf("b2b%0d.data", i), resp_data, exp4[i]);
    end
    req_valid = 0;
    @(negedge clock);
    check("b2b.idle", resp_valid, 0);

    // reset while row 7 is being written back
    do_reset();
    run_checked("r7.w", 1, 7, 0, 32'hCAFEF00D, 3, 32'h0);
    run_checked("r8.w", 1, 8, 0, 32'h12345678, 3, 32'h0);
    req_valid = 1; req_write = 1; req_row = 9; req_col = 0;
    req_data = 32'h9;
    @(posedge clock);
    #1 req_valid = 0;
    @(negedge clock);
    check("wb.busy", busy, 1);
    reset = 1;
    @(posedge clock);
    @(negedge clock);
    reset = 0;
    check("wbrst.ready", req_ready, 1);
    check("wbrst.busy", busy, 0);
    check("wbrst.resp_valid", resp_valid, 0);
    run_checked("r7.r", 0, 7, 0, 32'h0, 3, 32'h0);

    // random traffic against the row-array model
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      bit        wr;
      int        row;
      int        col;
      bit [31:0] d;
      int        elat;
      bit [31:0] erd;
      wr  = 1'($urandom_range(0, 1));
      row = $urandom_range(0, 5);
      col = $urandom_range(0, 255);
      d   = $urandom;
      elat = model_access(wr, row);
      if (wr) begin
        model_write(row, col, d);
        erd = 0;
      end else begin
        erd = model_read(row, col);
      end
      run_checked($sformatf("rnd%0d", i), wr, row, col, d, elat, erd);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

`ifdef BANK_FLUSH_EN
    do_reset();
    model_reset();
    run_checked("fl.w10", 1, 10, 0, 32'hA0A0A0A0, model_access(1, 10), 0);
    model_write(10, 0, 32'hA0A0A0A0);
    run_checked("fl.w11", 1, 11, 0, 32'hB1B1B1B1, model_access(1, 11), 0);
    model_write(11, 0, 32'hB1B1B1B1);
    flush_req = 1;
    check("fl.ready", req_ready, 0);
    @(posedge clock);
    #1 flush_req = 0;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      if (flush_done === 1'b1) begin
        lat = n;
        break;
      end
    end
    check("fl.done_lat", lat, 3);
    for (int i = 0; i < LINES; i++) cdirty[i] = 0;
    run_checked("fl.r12", 0, 12, 0, 0, model_access(0, 12), 0);
    run_checked("fl.r13", 0, 13, 0, 0, model_access(0, 13), 0);
    run_checked("fl.r10", 0, 10, 0, 0, model_access(0, 10), 32'hA0A0A0A0);
    run_checked("fl.r11", 0, 11, 0, 0, model_access(0, 11), 32'hB1B1B1B1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
